// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes, mux selects.
// Optional ILLEGAL_TRAP_EN adds a sticky TRAP state for unsupported opcodes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StJalr     = 4'd10,
        StJalrWb   = 4'd11,
        StBranch   = 4'd12,
        StLui      = 4'd13,
`ifdef ILLEGAL_TRAP_EN
        StAuipc    = 4'd14,
        StTrap     = 4'd15
`else
        StAuipc    = 4'd14
`endif
    } ctrl_state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [2:0] F3Beq  = 3'b000;
    localparam logic [2:0] F3Bne  = 3'b001;
    localparam logic [2:0] F3Blt  = 3'b100;
    localparam logic [2:0] F3Bge  = 3'b101;
    localparam logic [2:0] F3Bltu = 3'b110;
    localparam logic [2:0] F3Bgeu = 3'b111;

    // result mux select; 3'b100 is a reserved input and never driven by this FSM
    localparam logic [2:0] ResAluOut    = 3'b000;
    localparam logic [2:0] ResData      = 3'b001;
    localparam logic [2:0] ResAluResult = 3'b010;
    localparam logic [2:0] ResImmExt    = 3'b011;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    // state following DECODE for a given opcode
    function automatic ctrl_state_t decode_next(input logic [6:0] op);
        ctrl_state_t nxt;
        case (op)
            OpLoad, OpStore: nxt = StMemAdr;
            OpRtype:         nxt = StExecuteR;
            OpItype:         nxt = StExecuteI;
            OpJal:           nxt = StJal;
            OpJalr:          nxt = StJalr;
            OpBranch:        nxt = StBranch;
            OpLui:           nxt = StLui;
            OpAuipc:         nxt = StAuipc;
`ifdef ILLEGAL_TRAP_EN
            default:         nxt = StTrap;
`else
            default:         nxt = StFetch;
`endif
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
interface mc_control_fsm_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [2:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;

    modport master (
        input  op, funct3, zero, lt, ltu, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
        output result_src, alu_src_a, alu_src_b, alu_op, illegal
    );

    modport slave (
        output op, funct3, zero, lt, ltu, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
        input  result_src, alu_src_a, alu_src_b, alu_op, illegal
    );

endinterface

// File: rtl/mc_control_fsm_branch_eval.sv
// Branch condition from funct3 and the ALU compare flags; unused funct3 codes never branch.
module branch_eval
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3Beq:   taken = zero;
            F3Bne:   taken = ~zero;
            F3Blt:   taken = lt;
            F3Bge:   taken = ~lt;
            F3Bltu:  taken = ltu;
            F3Bgeu:  taken = ~ltu;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/memory/writeback sequencing.
// Build option ILLEGAL_TRAP_EN: unsupported opcodes lock into TRAP until reset.
module mc_control_fsm
    import riscv_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  ctrl
);

    ctrl_state_t state_q, state_d;

    logic       taken;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [2:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;

    branch_eval u_branch_eval (
        .funct3 (ctrl.funct3),
        .zero   (ctrl.zero),
        .lt     (ctrl.lt),
        .ltu    (ctrl.ltu),
        .taken  (taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = ResAluOut;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        alu_op     = AluAdd;
        illegal    = 1'b0;

        case (state_q)
            StFetch: begin
                alu_src_a  = SrcAPc;
                alu_src_b  = SrcBFour;
                alu_op     = AluAdd;
                result_src = ResAluResult;
                if (ctrl.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end
            end
            StDecode: begin
                // precompute branch/JAL target into ALUOut
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                state_d   = decode_next(ctrl.op);
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                state_d   = (ctrl.op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                adr_src = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src = ResData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ctrl.mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExecuteR: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBRs2;
                alu_op    = AluFunct;
                state_d   = StAluWb;
            end
            StExecuteI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // PC <- target held in ALUOut while ALU forms OldPC+4 for the link
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluOut;
                pc_write   = 1'b1;
                state_d    = StAluWb;
            end
            StJalr: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBImm;
                alu_op     = AluAdd;
                result_src = ResAluResult;
                pc_write   = 1'b1;
                state_d    = StJalrWb;
            end
            StJalrWb: begin
                alu_src_a  = SrcAOldPc;
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                alu_src_a  = SrcARs1;
                alu_src_b  = SrcBRs2;
                alu_op     = AluSub;
                result_src = ResAluOut;
                pc_write   = taken;
                state_d    = StFetch;
            end
            StLui: begin
                result_src = ResImmExt;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StAuipc: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                alu_op    = AluAdd;
                state_d   = StAluWb;
            end
`ifdef ILLEGAL_TRAP_EN
            StTrap: begin
                illegal = 1'b1;
                state_d = StTrap;
            end
`endif
            default: begin
                state_d = StFetch;
            end
        endcase

        // reset abandons whatever is in flight with no side effects
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign ctrl.pc_write   = pc_write;
    assign ctrl.adr_src    = adr_src;
    assign ctrl.mem_write  = mem_write;
    assign ctrl.ir_write   = ir_write;
    assign ctrl.reg_write  = reg_write;
    assign ctrl.result_src = result_src;
    assign ctrl.alu_src_a  = alu_src_a;
    assign ctrl.alu_src_b  = alu_src_b;
    assign ctrl.alu_op     = alu_op;
    assign ctrl.illegal    = illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; honours ILLEGAL_TRAP_EN for the illegal-opcode case.
module tb_mc_control_fsm;

    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    mc_control_fsm_if bus ();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .ctrl  (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, alu_op, illegal}
    logic [14:0] outv;
    assign outv = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                   bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.illegal};

    function automatic logic [14:0] ctl(input logic pcw, input logic adr, input logic mw,
                                        input logic irw, input logic rw, input logic [2:0] rs,
                                        input logic [1:0] a, input logic [1:0] b,
                                        input logic [1:0] aop, input logic ill);
        return {pcw, adr, mw, irw, rw, rs, a, b, aop, ill};
    endfunction

    task automatic check_eq(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // inputs are set just after posedge; outputs checked at the following negedge
    task automatic step(input string tag, input logic [14:0] exp);
        @(negedge clk);
        check_eq(tag, outv, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic step_en_off(input string tag, input logic [14:0] mask);
        @(negedge clk);
        check_eq(tag, outv & mask, 15'd0);
        @(posedge clk);
        #1;
    endtask

    logic [14:0] fet, fet_wait, dec, memadr, memrd, memwb, memwr, aluwb, enmask;
    logic [8:0]  br_vec [10];

    initial begin
        n_total = 0;
        n_bad   = 0;
        fet      = ctl(1, 0, 0, 1, 0, 3'b010, 2'b00, 2'b10, 2'b00, 0);
        fet_wait = ctl(0, 0, 0, 0, 0, 3'b010, 2'b00, 2'b10, 2'b00, 0);
        dec      = ctl(0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b01, 2'b00, 0);
        memadr   = ctl(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 2'b00, 0);
        memrd    = ctl(0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0);
        memwb    = ctl(0, 0, 0, 0, 1, 3'b001, 2'b00, 2'b00, 2'b00, 0);
        memwr    = ctl(0, 1, 1, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 0);
        aluwb    = ctl(0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 2'b00, 0);
        enmask   = ctl(1, 0, 1, 1, 1, 3'b000, 2'b00, 2'b00, 2'b00, 1);

        // {funct3, zero, lt, ltu, taken, pad}
        br_vec[0] = {3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        br_vec[1] = {3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        br_vec[2] = {3'b010, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};
        br_vec[3] = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        br_vec[4] = {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
        br_vec[5] = {3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        br_vec[6] = {3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        br_vec[7] = {3'b110, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00};
        br_vec[8] = {3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        br_vec[9] = {3'b011, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00};

        reset         = 1'b1;
        bus.op        = 7'b0000000;
        bus.funct3    = 3'b000;
        bus.zero      = 1'b0;
        bus.lt        = 1'b0;
        bus.ltu       = 1'b0;
        bus.mem_ready = 1'b1;

        step_en_off("rst_cyc0", enmask);
        step_en_off("rst_cyc1", enmask);
        reset = 1'b0;

        // load with two memory wait cycles
        bus.op = 7'b0000011;
        step("ld_fetch", fet);
        step("ld_decode", dec);
        step("ld_memadr", memadr);
        bus.mem_ready = 1'b0;
        step("ld_read_w1", memrd);
        step("ld_read_w2", memrd);
        bus.mem_ready = 1'b1;
        step("ld_read", memrd);
        step("ld_memwb", memwb);

        // bne, then flags/funct3 swept combinationally inside the BRANCH cycle
        bus.op     = 7'b1100011;
        bus.funct3 = 3'b001;
        step("br_fetch", fet);
        step("br_decode", dec);
        check_eq("br_state", outv, ctl(1, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b01, 0));
        for (int i = 0; i < 10; i++) begin
            bus.funct3 = br_vec[i][8:6];
            bus.zero   = br_vec[i][5];
            bus.lt     = br_vec[i][4];
            bus.ltu    = br_vec[i][3];
            #1;
            check_eq($sformatf("br_taken%0d", i), {14'd0, bus.pc_write},
                     {14'd0, br_vec[i][2]});
        end
        @(posedge clk);
        #1;

        // jalr
        bus.op = 7'b1100111;
        step("jalr_fetch", fet);
        step("jalr_decode", dec);
        step("jalr_exec", ctl(1, 0, 0, 0, 0, 3'b010, 2'b10, 2'b01, 2'b00, 0));
        step("jalr_wb", ctl(0, 0, 0, 0, 1, 3'b010, 2'b01, 2'b10, 2'b00, 0));

        // lui
        bus.op = 7'b0110111;
        step("lui_fetch", fet);
        step("lui_decode", dec);
        step("lui_wb", ctl(0, 0, 0, 0, 1, 3'b011, 2'b00, 2'b00, 2'b00, 0));

        // store with a fetch wait and a write wait
        bus.op        = 7'b0100011;
        bus.mem_ready = 1'b0;
        step("st_fetch_wait", fet_wait);
        bus.mem_ready = 1'b1;
        step("st_fetch", fet);
        step("st_decode", dec);
        step("st_memadr", memadr);
        bus.mem_ready = 1'b0;
        step("st_write_wait", memwr);
        bus.mem_ready = 1'b1;
        step("st_write", memwr);

        // r-type
        bus.op = 7'b0110011;
        step("r_fetch", fet);
        step("r_decode", dec);
        step("r_exec", ctl(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 2'b10, 0));
        step("r_wb", aluwb);

        // i-type
        bus.op = 7'b0010011;
        step("i_fetch", fet);
        step("i_decode", dec);
        step("i_exec", ctl(0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 2'b10, 0));
        step("i_wb", aluwb);

        // jal
        bus.op = 7'b1101111;
        step("jal_fetch", fet);
        step("jal_decode", dec);
        step("jal_exec", ctl(1, 0, 0, 0, 0, 3'b000, 2'b01, 2'b10, 2'b00, 0));
        step("jal_wb", aluwb);

        // auipc
        bus.op = 7'b0010111;
        step("auipc_fetch", fet);
        step("auipc_decode", dec);
        step("auipc_exec", ctl(0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b01, 2'b00, 0));
        step("auipc_wb", aluwb);

        // reset asserted while a store waits in MEMWRITE
        bus.op = 7'b0100011;
        step("rs_fetch", fet);
        step("rs_decode", dec);
        step("rs_memadr", memadr);
        bus.mem_ready = 1'b0;
        reset         = 1'b1;
        step_en_off("rs_midreset", enmask);
        reset         = 1'b0;
        bus.mem_ready = 1'b1;
        step("rs_refetch", fet);

        // unsupported opcode
        bus.op = 7'b1111111;
        step("ill_decode", dec);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            step($sformatf("ill_trap%0d", i), ctl(0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 2'b00, 1));
        end
        reset = 1'b1;
        step_en_off("ill_reset", enmask);
        reset  = 1'b0;
        bus.op = 7'b0110111;
        step("ill_after_reset", fet);
`else
        step("ill_nop_fetch", fet);
        step("ill_nop_decode", dec);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
